// File: rtl/seq_frame_tx_pkg.sv
// Shared types and constants for the serial frame transmitter and its detector peer.
package seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SYNC = 2'd1,
    ST_DATA = 2'd2,
    ST_GAP  = 2'd3
  } state_e;

  localparam logic [3:0] SYNC_PAT_DEFAULT = 4'b1001;

  // Three trailing zeros drive the 1001 detector back to idle from any state.
  localparam int MIN_GAP = 3;

  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m > 1) ? $clog2(m) : 1;
  endfunction

endpackage

// File: rtl/seq_frame_tx_if.sv
// Producer-side handshake plus serial line and status of the frame transmitter.
interface seq_frame_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              dout;
  logic              busy;
  logic              frame_done;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, dout, busy, frame_done
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, dout, busy, frame_done
  );
endinterface

// File: rtl/seq_frame_tx_piso.sv
// Parallel-in/serial-out register: MSB is presented first, shifts left on enable.
module piso_shift #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr_i,
  input  logic         load_i,
  input  logic         shift_i,
  input  logic [W-1:0] data_i,
  output logic         msb_o
);
  logic [W-1:0] sr_q;
  logic [W-1:0] sr_d;
  logic [W-1:0] shifted;

  generate
    if (W == 1) begin : g_one
      assign shifted = '0;
    end else begin : g_many
      assign shifted = {sr_q[W-2:0], 1'b0};
    end
  endgenerate

  always_comb begin
    sr_d = sr_q;
    if (load_i) begin
      sr_d = data_i;
    end else if (shift_i) begin
      sr_d = shifted;
    end
  end

  always_ff @(posedge clk) begin
    if (clr_i) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign msb_o = sr_q[W-1];
endmodule

// File: rtl/seq_frame_tx.sv
// Frames each accepted word as sync pattern, MSB-first payload and zero guard run
// on a registered serial line.
module seq_frame_tx
  import seq_pkg::*;
#(
  parameter int                DATA_W   = 8,
  parameter int                SYNC_W   = 4,
  parameter logic [SYNC_W-1:0] SYNC_PAT = SYNC_PAT_DEFAULT,
  parameter int                GAP_LEN  = 3
) (
  input  logic          clk,
  input  logic          rst,
  seq_frame_tx_if.slave bus
);
  localparam int CNT_W = cnt_width(SYNC_W, DATA_W, GAP_LEN);
  localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_LEN - 1);

  generate
    if (GAP_LEN < MIN_GAP) begin : g_gap_chk
      $error("seq_frame_tx: GAP_LEN too short for detector resync");
    end
    if (DATA_W < 1 || DATA_W > 32) begin : g_width_chk
      $error("seq_frame_tx: DATA_W outside 1..32");
    end
  endgenerate

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             dout_q;
  logic             ready_q;
  logic             busy_q;
  logic             done_q;

  logic accept;
  logic sr_load;
  logic sr_shift;
  logic sr_msb;
  logic sync_next_bit;

  assign accept = bus.tx_valid && ready_q;

  always_comb begin
    sr_load  = (state_q == ST_IDLE) && accept;
    sr_shift = ((state_q == ST_SYNC) && (cnt_q == SYNC_LAST)) ||
               ((state_q == ST_DATA) && (cnt_q != DATA_LAST));
  end

  // Sync bit that follows the one currently on the line (constant indices only).
  always_comb begin
    sync_next_bit = 1'b0;
    for (int i = 0; i < SYNC_W - 1; i++) begin
      if (cnt_q == CNT_W'(i)) begin
        sync_next_bit = SYNC_PAT[SYNC_W-2-i];
      end
    end
  end

  piso_shift #(
    .W (DATA_W)
  ) u_piso (
    .clk     (clk),
    .clr_i   (rst),
    .load_i  (sr_load),
    .shift_i (sr_shift),
    .data_i  (bus.tx_data),
    .msb_o   (sr_msb)
  );

  // dout_q is loaded one edge ahead so the line bit lines up with the state it belongs to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dout_q  <= 1'b0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          dout_q <= 1'b0;
          if (accept) begin
            state_q <= ST_SYNC;
            cnt_q   <= '0;
            dout_q  <= SYNC_PAT[SYNC_W-1];
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        ST_SYNC: begin
          if (cnt_q == SYNC_LAST) begin
            state_q <= ST_DATA;
            cnt_q   <= '0;
            dout_q  <= sr_msb;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            dout_q <= sync_next_bit;
          end
        end
        ST_DATA: begin
          if (cnt_q == DATA_LAST) begin
            state_q <= ST_GAP;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
          end else begin
            cnt_q  <= cnt_q + 1'b1;
            dout_q <= sr_msb;
          end
        end
        ST_GAP: begin
          dout_q <= 1'b0;
          if (cnt_q == GAP_LAST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.tx_ready   = ready_q;
  assign bus.dout       = dout_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = done_q;
endmodule

// File: tb/tb_seq_frame_tx.sv
// Directed and table-driven checks of seq_frame_tx framing, handshake and reset abort.
module tb_seq_frame_tx;
  logic clk = 1'b0;
  logic rst = 1'b1;

  seq_frame_tx_if #(.DATA_W(8)) bus ();

  seq_frame_tx #(
    .DATA_W  (8),
    .SYNC_W  (4),
    .SYNC_PAT(4'b1001),
    .GAP_LEN (3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int cyc   = 0;
  int det_q = 0;
  bit det_hit;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [7:0]  data;
    logic [14:0] frame;
    string       name;
  } vec_t;

  vec_t vecs [5];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Overlapping 1001 detector: state is the length of the matched prefix.
  task automatic det_step(input logic b);
    det_hit = 1'b0;
    case (det_q)
      0: det_q = b ? 1 : 0;
      1: det_q = b ? 1 : 2;
      2: det_q = b ? 1 : 3;
      default: begin
        if (b) begin
          det_hit = 1'b1;
          det_q   = 1;
        end else begin
          det_q = 0;
        end
      end
    endcase
  endtask

  function automatic logic [31:0] status();
    return 32'({bus.frame_done, bus.busy, bus.tx_ready, bus.dout});
  endfunction

  // Called at the sample point of the accept cycle T; returns at T+16.
  task automatic send(input logic [7:0] d, input logic [14:0] exp, input string nm,
                      input bit chain, input logic [7:0] nd, output int fd_cyc);
    logic [14:0] got;
    bit busy_ok;
    bit sync_hit;
    chk({nm, " ready_at_T"}, 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    det_q    = 0;
    got      = '0;
    busy_ok  = 1'b1;
    sync_hit = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      tick();
      if (i == 1) bus.tx_valid = chain;
      if (i == 2) bus.tx_data = ~d;
      got = {got[13:0], bus.dout};
      if (!(bus.busy && !bus.tx_ready && !bus.frame_done)) busy_ok = 1'b0;
      det_step(bus.dout);
      if (i == 4) sync_hit = det_hit;
    end
    chk({nm, " frame_bits"}, 32'(got), 32'(exp));
    chk({nm, " busy_during"}, 32'(busy_ok), 32'd1);
    chk({nm, " sync_detected"}, 32'(sync_hit), 32'd1);
    tick();
    chk({nm, " done_cycle"}, status(), 32'(4'b1010));
    chk({nm, " detector_idle"}, 32'(det_q), 32'd0);
    fd_cyc = cyc;
    if (chain) bus.tx_data = nd;
  endtask

  initial begin
    int c1, c2;
    bit saw_done;
    logic [7:0] rd;

    vecs[0] = '{8'hA5, 15'b1001_1010_0101_000, "A5"};
    vecs[1] = '{8'h3C, 15'b1001_0011_1100_000, "3C_then_C3"};
    vecs[2] = '{8'hFF, 15'b1001_1111_1111_000, "FF"};
    vecs[3] = '{8'h00, 15'b1001_0000_0000_000, "00"};
    vecs[4] = '{8'h96, 15'b1001_1001_0110_000, "96_payload_1001"};

    bus.tx_valid = 1'b0;
    bus.tx_data  = '0;
    rst = 1'b1;
    tick();
    tick();
    chk("reset_state", status(), 32'(4'b0010));
    rst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      tick();
      chk("idle_after_reset", status(), 32'(4'b0010));
    end

    for (int i = 0; i < 5; i++) begin
      send(vecs[i].data, vecs[i].frame, vecs[i].name, 1'b0, 8'h00, c1);
      tick();
      chk({vecs[i].name, " done_clears"}, status(), 32'(4'b0010));
    end

    // Back-to-back: valid held high across FF then 00.
    send(8'hFF, 15'b1001_1111_1111_000, "chain_FF", 1'b1, 8'h00, c1);
    send(8'h00, 15'b1001_0000_0000_000, "chain_00", 1'b0, 8'h00, c2);
    chk("chain_period", 32'(c2 - c1), 32'd16);
    tick();
    chk("chain_done_clears", status(), 32'(4'b0010));

    // Reset mid-payload at T+7.
    bus.tx_data  = 8'hA5;
    bus.tx_valid = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      tick();
      if (i == 1) bus.tx_valid = 1'b0;
    end
    chk("abort_busy_before_reset", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    tick();
    chk("abort_reset_next_cycle", status(), 32'(4'b0010));
    rst = 1'b0;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.frame_done || bus.busy || bus.dout) saw_done = 1'b1;
    end
    chk("abort_no_frame_done", 32'(saw_done), 32'd0);
    send(8'hA5, 15'b1001_1010_0101_000, "after_abort", 1'b0, 8'h00, c1);
    tick();

    for (int i = 0; i < 6; i++) begin
      rd = 8'($urandom_range(0, 255));
      send(rd, {4'b1001, rd, 3'b000}, "random", 1'b0, 8'h00, c1);
      tick();
      chk("random_done_clears", status(), 32'(4'b0010));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
